// File: rtl/punc_core_mc_if.sv
// Request/acknowledge memory port between the PUnC core (master) and a memory model (slave).
// Address/we/wdata are held by the master from the first request cycle through the ack cycle.
interface punc_core_mc_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/punc_core_mc.sv
// Multi-cycle PUnC (LC3-subset) core: FETCH/EXEC/IND/MEM/HALT controller, 8x16 register file
// and a variable-latency request/acknowledge memory port.
module punc_core_mc #(
  parameter int unsigned ADDR_W          = 16,
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  punc_core_mc_if.master        bus,
  output logic                  halted,
  input  logic [2:0]            rf_debug_addr,
  output logic [15:0]           rf_debug_data,
  output logic [15:0]           pc_debug_data
);

  typedef enum logic [2:0] {StFetch, StExec, StInd, StMem, StHalt} state_e;

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpLdr  = 4'b0110;
  localparam logic [3:0] OpStr  = 4'b0111;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpLdi  = 4'b1010;
  localparam logic [3:0] OpSti  = 4'b1011;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpLea  = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ea_q, ea_d;
  logic [15:0] rf_q [8];
  logic        n_q, z_q, p_q;

  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        cc_we;

  logic [3:0]  opcode;
  logic [2:0]  dr;
  logic [15:0] sr1_val, sr2_val, op2;
  logic [15:0] sext6, sext9, sext11, imm5;
  logic        is_store;
  logic        br_taken;
  logic        ack;
  logic [15:0] addr_full;

  assign opcode  = ir_q[15:12];
  assign dr      = ir_q[11:9];
  assign sr1_val = rf_q[ir_q[8:6]];
  assign sr2_val = rf_q[ir_q[2:0]];
  assign imm5    = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sext6   = {{10{ir_q[5]}}, ir_q[5:0]};
  assign sext9   = {{7{ir_q[8]}}, ir_q[8:0]};
  assign sext11  = {{5{ir_q[10]}}, ir_q[10:0]};
  assign op2     = ir_q[5] ? imm5 : sr2_val;

  assign is_store = (opcode == OpSt) || (opcode == OpStr) || (opcode == OpSti);
  assign br_taken = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q);

  // Request is combinational on rst so an abandoned access drops immediately.
  assign bus.mem_req   = !rst && ((state_q == StFetch) || (state_q == StInd)
                                  || (state_q == StMem));
  assign bus.mem_we    = (state_q == StMem) && is_store;
  assign addr_full     = (state_q == StFetch) ? pc_q : ea_q;
  assign bus.mem_addr  = addr_full[ADDR_W-1:0];
  assign bus.mem_wdata = rf_q[dr];
  assign ack           = bus.mem_ack && bus.mem_req;

  assign halted        = (state_q == StHalt);
  assign rf_debug_data = rf_q[rf_debug_addr];
  assign pc_debug_data = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ea_d     = ea_q;
    rf_we    = 1'b0;
    rf_waddr = dr;
    rf_wdata = 16'h0000;
    cc_we    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (ack) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        case (opcode)
          OpAdd: begin
            rf_we    = 1'b1;
            rf_wdata = sr1_val + op2;
            cc_we    = 1'b1;
          end
          OpAnd: begin
            rf_we    = 1'b1;
            rf_wdata = sr1_val & op2;
            cc_we    = 1'b1;
          end
          OpNot: begin
            rf_we    = 1'b1;
            rf_wdata = ~sr1_val;
            cc_we    = 1'b1;
          end
          OpBr: begin
            if (br_taken) pc_d = pc_q + sext9;
          end
          OpJmp: pc_d = sr1_val;
          OpJsr: begin
            // Base register was sampled above, so JSRR R7 still jumps to the old R7.
            rf_we    = 1'b1;
            rf_waddr = 3'd7;
            rf_wdata = pc_q;
            pc_d     = ir_q[11] ? (pc_q + sext11) : sr1_val;
          end
          OpLea: begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + sext9;
          end
          OpLd, OpSt: begin
            ea_d    = pc_q + sext9;
            state_d = StMem;
          end
          OpLdr, OpStr: begin
            ea_d    = sr1_val + sext6;
            state_d = StMem;
          end
          OpLdi, OpSti: begin
            ea_d    = pc_q + sext9;
            state_d = StInd;
          end
          OpTrap: state_d = StHalt;
          default: state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
        endcase
      end
      StInd: begin
        if (ack) begin
          ea_d    = bus.mem_rdata;
          state_d = StMem;
        end
      end
      StMem: begin
        if (ack) begin
          if (!is_store) begin
            rf_we    = 1'b1;
            rf_wdata = bus.mem_rdata;
            cc_we    = 1'b1;
          end
          state_d = StFetch;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ea_q    <= 16'h0000;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      p_q     <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
      if (cc_we) begin
        n_q <= rf_wdata[15];
        z_q <= (rf_wdata == 16'h0000);
        p_q <= !rf_wdata[15] && (rf_wdata != 16'h0000);
      end
    end
  end

endmodule
